// File: rtl/bridge_cmd_channel.sv
// bridge_cmd_channel: memory-mapped command channel between a register bridge
// and a command-executing core. A "CM" write to BASE launches a command built
// from the parameter registers. The core reports progress and completion, and
// the result and response words are read back through the bridge.
// Optional feature macro: BRIDGE_CMD_TIMEOUT_EN. When it is defined, a command
// that stays in VALID for TIMEOUT_CYCLES cycles is aborted with an "ER" status.
module bridge_cmd_channel #(
  parameter logic [31:0] BASE             = 32'hF8000000,
  parameter logic [31:0] PARAMETER_OFFSET = 32'h20,
  parameter logic [31:0] RESPONSE_OFFSET  = 32'h40,
  parameter int          N_WORDS          = 4,
  parameter logic [31:0] TIMEOUT_CYCLES   = 32'd1048576
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            bridge_addr,
  input  logic                   bridge_wr,
  input  logic [31:0]            bridge_wr_data,
  input  logic                   bridge_rd,
  output logic [31:0]            bridge_rd_data,
  output logic                   cmd_valid,
  output logic [15:0]            cmd_word,
  output logic [32*N_WORDS-1:0]  cmd_param,
  input  logic [15:0]            cmd_progress,
  input  logic                   cmd_done,
  input  logic [15:0]            cmd_result,
  input  logic [32*N_WORDS-1:0]  cmd_response
);

  localparam logic [15:0] TAG_CM = 16'h434D;
  localparam logic [15:0] TAG_BU = 16'h4255;
  localparam logic [15:0] TAG_OK = 16'h4F4B;
  localparam logic [15:0] TAG_ER = 16'h4552;
  localparam logic [29:0] N_WORDS_W = 30'(N_WORDS);

  typedef enum logic [1:0] {IDLE, VALID, DONE} state_t;

  state_t      state_reg;
  logic [31:0] status_reg;
  logic [15:0] collision_reg;
  logic [31:0] param_reg [N_WORDS];
  logic [31:0] resp_reg  [N_WORDS];
  logic [31:0] rd_data_next;

  // Reads are free-running, so the read strobe carries no information.
  logic unused_rd;
  assign unused_rd = bridge_rd;

  // Address decode relative to BASE and to the two word windows
  logic [31:0] offset;
  logic [31:0] param_rel;
  logic [31:0] resp_rel;
  logic        param_hit;
  logic        resp_hit;
  logic        cmd_start;
  logic [N_WORDS-1:0] param_we;

  assign offset    = bridge_addr - BASE;
  assign param_rel = offset - PARAMETER_OFFSET;
  assign resp_rel  = offset - RESPONSE_OFFSET;
  assign param_hit = (param_rel[31:2] < N_WORDS_W) && (param_rel[1:0] == 2'b00);
  assign resp_hit  = (resp_rel[31:2] < N_WORDS_W) && (resp_rel[1:0] == 2'b00);
  assign cmd_start = bridge_wr && (offset == 32'h0) && (bridge_wr_data[31:16] == TAG_CM);

  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_param_we
      assign param_we[gi] = bridge_wr && param_hit && (param_rel[4:2] == 3'(gi));
    end
  endgenerate

`ifdef BRIDGE_CMD_TIMEOUT_EN
  logic [31:0] timer_reg;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // Parameter registers accept writes in every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_WORDS; i++) param_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N_WORDS; i++)
        if (param_we[i]) param_reg[i] <= bridge_wr_data;
    end
  end

  // Command FSM: launch, track progress, capture completion, count collisions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cmd_valid     <= 1'b0;
      cmd_word      <= '0;
      cmd_param     <= '0;
      status_reg    <= '0;
      collision_reg <= '0;
      for (int i = 0; i < N_WORDS; i++) resp_reg[i] <= '0;
`ifdef BRIDGE_CMD_TIMEOUT_EN
      timer_reg     <= '0;
`endif
    end else begin
      // A launch attempt while busy is rejected and counted
      if (cmd_start && (state_reg != IDLE) && (collision_reg != 16'hFFFF))
        collision_reg <= collision_reg + 16'd1;
      case (state_reg)
        IDLE: begin
          if (cmd_start) begin
            cmd_word   <= bridge_wr_data[15:0];
            for (int i = 0; i < N_WORDS; i++) cmd_param[32*i +: 32] <= param_reg[i];
            status_reg <= {TAG_BU, 16'h0};
            cmd_valid  <= 1'b1;
            state_reg  <= VALID;
`ifdef BRIDGE_CMD_TIMEOUT_EN
            timer_reg  <= '0;
`endif
          end
        end
        VALID: begin
          if (cmd_done) begin
            status_reg <= {TAG_OK, cmd_result};
            for (int i = 0; i < N_WORDS; i++) resp_reg[i] <= cmd_response[32*i +: 32];
            cmd_valid  <= 1'b0;
            state_reg  <= DONE;
          end
`ifdef BRIDGE_CMD_TIMEOUT_EN
          else if (timer_reg == TIMEOUT_CYCLES - 32'd1) begin
            status_reg <= {TAG_ER, 16'hFFFF};
            for (int i = 0; i < N_WORDS; i++) resp_reg[i] <= '0;
            cmd_valid  <= 1'b0;
            state_reg  <= DONE;
          end
`endif
          else begin
            status_reg <= {TAG_BU, cmd_progress};
`ifdef BRIDGE_CMD_TIMEOUT_EN
            timer_reg  <= timer_reg + 32'd1;
`endif
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Read mux for the current address
  always_comb begin
    rd_data_next = 32'hFFFFFFFF;
    if (offset == 32'h0)      rd_data_next = status_reg;
    else if (offset == 32'h4) rd_data_next = PARAMETER_OFFSET;
    else if (offset == 32'h8) rd_data_next = RESPONSE_OFFSET;
    else if (offset == 32'hC) rd_data_next = {collision_reg, 16'h0};
    else if (resp_hit) begin
      for (int i = 0; i < N_WORDS; i++)
        if (resp_rel[4:2] == 3'(i)) rd_data_next = resp_reg[i];
    end
  end

  // Registered read data, refreshed every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bridge_rd_data <= '0;
    else       bridge_rd_data <= rd_data_next;
  end

endmodule

// File: tb/tb_bridge_cmd_channel.sv
// Testbench for bridge_cmd_channel: two instances (4 and 2 words) share one
// bus; read expectations go through a scoreboard queue.
// Timeout scenario compiled only with BRIDGE_CMD_TIMEOUT_EN.
module tb_bridge_cmd_channel;
  localparam logic [31:0] BASE = 32'hF8000000;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  bridge_addr = '0;
  logic         bridge_wr = 1'b0;
  logic [31:0]  bridge_wr_data = '0;
  logic         bridge_rd = 1'b0;
  logic [31:0]  bridge_rd_data, bridge_rd_data2;
  logic         cmd_valid, cmd_valid2;
  logic [15:0]  cmd_word, cmd_word2;
  logic [127:0] cmd_param;
  logic [63:0]  cmd_param2;
  logic [15:0]  cmd_progress = '0;
  logic         cmd_done = 1'b0;
  logic [15:0]  cmd_result = '0;
  logic [127:0] cmd_response = {32'hA3A30003, 32'hA2A20002, 32'hA1A10001, 32'hA0A00000};

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp2_q[$];

  always #5 clk = ~clk;

  bridge_cmd_channel #(.N_WORDS(4), .TIMEOUT_CYCLES(32'd16)) dut (
    .clk(clk), .reset(reset), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
    .cmd_valid(cmd_valid), .cmd_word(cmd_word), .cmd_param(cmd_param),
    .cmd_progress(cmd_progress), .cmd_done(cmd_done), .cmd_result(cmd_result),
    .cmd_response(cmd_response));

  bridge_cmd_channel #(.N_WORDS(2), .TIMEOUT_CYCLES(32'd16)) dut2 (
    .clk(clk), .reset(reset), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
    .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data2),
    .cmd_valid(cmd_valid2), .cmd_word(cmd_word2), .cmd_param(cmd_param2),
    .cmd_progress(cmd_progress), .cmd_done(cmd_done), .cmd_result(cmd_result),
    .cmd_response(cmd_response[63:0]));

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    bridge_addr = a; bridge_wr = 1'b1; bridge_wr_data = d;
    @(posedge clk); #1;
    bridge_wr = 1'b0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [31:0] d2);
    bridge_addr = a; bridge_rd = 1'b1;
    @(posedge clk); #1;
    bridge_rd = 1'b0;
    d = bridge_rd_data; d2 = bridge_rd_data2;
    $display("read  addr=%h data=%h data2=%h", a, d, d2);
  endtask

  task automatic finish_cmd(input logic [15:0] r);
    cmd_result = r; cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [6];
    logic [31:0] got, got2, e;
    addrs = '{BASE, BASE + 32'hC, BASE + 32'h4, BASE + 32'h8, BASE + 32'h40, BASE + 32'h100};
    bridge_addr = BASE + 32'h4;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || cmd_word !== 16'h0 || cmd_param !== '0) begin
      n_fail++; $display("FAIL reset_cmd: valid=%b word=%h param=%h want 0", cmd_valid, cmd_word, cmd_param);
    end
    n_checks++;
    if (bridge_rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_data: got %h want 00000000", bridge_rd_data);
    end
    reset = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hFFFFFFFF);
    for (int i = 0; i < 6; i++) begin
      do_read(addrs[i], got, got2);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL reset_read%0d: addr %h got %h want %h", i, addrs[i], got, e);
      end
    end
  endtask

  task automatic test_basic();
    logic [31:0] addrs [5];
    logic [31:0] got, got2, e;
    addrs = '{BASE, BASE + 32'h40, BASE + 32'h4C, BASE + 32'h4, BASE + 32'hC};
    for (int i = 0; i < 4; i++) do_write(BASE + 32'h20 + 32'(4 * i), 32'(i + 1));
    cmd_progress = 16'h0007;
    do_write(BASE, 32'h434D0042);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_word !== 16'h0042) begin
      n_fail++; $display("FAIL basic_launch: valid=%b word=%h want 1 0042", cmd_valid, cmd_word);
    end
    n_checks++;
    if (cmd_param[31:0] !== 32'h1 || cmd_param[127:96] !== 32'h4) begin
      n_fail++; $display("FAIL basic_param: got %h want 00000004_..._00000001", cmd_param);
    end
    n_checks++;
    if (cmd_param2 !== {32'h2, 32'h1}) begin
      n_fail++; $display("FAIL basic_param2: got %h want 0000000200000001", cmd_param2);
    end
    exp_q.push_back(32'h42550000);
    exp_q.push_back(32'h42550007);
    for (int i = 0; i < 2; i++) begin
      do_read(BASE, got, got2);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL basic_busy%0d: got %h want %h", i, got, e);
      end
    end
    cmd_result = 16'h0005; cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_valid: got %b want 0", cmd_valid);
    end
    exp_q.push_back(32'h4F4B0005);
    exp_q.push_back(32'hA0A00000);
    exp_q.push_back(32'hA3A30003);
    exp_q.push_back(32'h20);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 5; i++) begin
      do_read(addrs[i], got, got2);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e) begin
        n_fail++; $display("FAIL basic_read%0d: addr %h got %h want %h", i, addrs[i], got, e);
      end
    end
    // cmd_done while idle must not disturb the status
    cmd_result = 16'hBEEF; cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    exp_q.push_back(32'h4F4B0005);
    do_read(BASE, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_done_ignored: status %h valid %b want %h 0", got, cmd_valid, e);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [4];
    logic [31:0] got, got2, e, e2;
    addrs = '{BASE + 32'h28, BASE + 32'h100, BASE + 32'h48, BASE + 32'h44};
    do_write(BASE + 32'h20, 32'h11);
    do_write(BASE + 32'h24, 32'h22);
    do_write(BASE + 32'h28, 32'h33);
    exp_q.push_back(32'hFFFFFFFF); exp2_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'hFFFFFFFF); exp2_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'hA2A20002); exp2_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'hA1A10001); exp2_q.push_back(32'hA1A10001);
    for (int i = 0; i < 4; i++) begin
      do_read(addrs[i], got, got2);
      e = exp_q.pop_front(); e2 = exp2_q.pop_front();
      n_checks++;
      if (got !== e || got2 !== e2) begin
        n_fail++; $display("FAIL unmapped_read%0d: addr %h got %h/%h want %h/%h", i, addrs[i], got, got2, e, e2);
      end
    end
    do_write(BASE, 32'h434D0001);
    n_checks++;
    if (cmd_param2 !== {32'h22, 32'h11} || cmd_param[95:64] !== 32'h33) begin
      n_fail++; $display("FAIL unmapped_param: got %h/%h want 0000002200000011/00000033", cmd_param2, cmd_param[95:64]);
    end
    finish_cmd(16'h0001);
  endtask

  task automatic test_param_stability();
    do_write(BASE + 32'h20, 32'h1000);
    do_write(BASE, 32'h434D0077);
    do_write(BASE + 32'h20, 32'hDEAD);
    @(posedge clk); #1;
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_param[31:0] !== 32'h1000) begin
      n_fail++; $display("FAIL param_stable_valid: valid %b param0 %h want 1 00001000", cmd_valid, cmd_param[31:0]);
    end
    finish_cmd(16'h0002);
    n_checks++;
    if (cmd_param[31:0] !== 32'h1000) begin
      n_fail++; $display("FAIL param_stable_idle: got %h want 00001000", cmd_param[31:0]);
    end
    do_write(BASE, 32'h434D0078);
    n_checks++;
    if (cmd_param[31:0] !== 32'hDEAD) begin
      n_fail++; $display("FAIL param_next_cmd: got %h want 0000dead", cmd_param[31:0]);
    end
    finish_cmd(16'h0003);
  endtask

  task automatic test_collision();
    logic [31:0] got, got2, e;
    do_write(BASE, 32'h12340011);
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL non_cm_ignored: valid %b want 0", cmd_valid);
    end
    do_write(BASE, 32'h434D0011);
    do_write(BASE, 32'h434D0099);
    do_write(BASE, 32'h55550022);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_word !== 16'h0011) begin
      n_fail++; $display("FAIL collision_no_restart: valid %b word %h want 1 0011", cmd_valid, cmd_word);
    end
    exp_q.push_back(32'h00010000);
    do_read(BASE + 32'hC, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL collision_count1: got %h want %h", got, e);
    end
    cmd_result = 16'h0004; cmd_done = 1'b1;
    @(posedge clk); #1;
    cmd_done = 1'b0;
    // This write lands on the single DONE cycle
    do_write(BASE, 32'h434D0055);
    n_checks++;
    if (cmd_valid !== 1'b0 || cmd_word !== 16'h0011) begin
      n_fail++; $display("FAIL collision_in_done: valid %b word %h want 0 0011", cmd_valid, cmd_word);
    end
    exp_q.push_back(32'h00020000);
    do_read(BASE + 32'hC, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL collision_count2: got %h want %h", got, e);
    end
  endtask

  task automatic test_reset_mid_valid();
    logic [31:0] got, got2, e;
    cmd_progress = 16'h1234;
    do_write(BASE, 32'h434D00AA);
    @(posedge clk); #1;
    bridge_addr = BASE;
    reset = 1'b1;
    #1;
    n_checks++;
    if (cmd_valid !== 1'b0 || bridge_rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_async: valid %b rd %h want 0 00000000", cmd_valid, bridge_rd_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 2; i++) begin
      do_read(BASE, got, got2);
      e = exp_q.pop_front();
      n_checks++;
      if (got !== e || cmd_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_abandon%0d: status %h valid %b want %h 0", i, got, cmd_valid, e);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_write(BASE, 32'h434D00BB);
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_word !== 16'h00BB) begin
      n_fail++; $display("FAIL first_clk_start: valid %b word %h want 1 00bb", cmd_valid, cmd_word);
    end
    exp_q.push_back(32'h42550000);
    do_read(BASE, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL restart_status: got %h want %h", got, e);
    end
    finish_cmd(16'h0009);
    exp_q.push_back(32'h4F4B0009);
    do_read(BASE, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL restart_done: got %h want %h", got, e);
    end
  endtask

`ifdef BRIDGE_CMD_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] got, got2, e;
    cmd_progress = 16'h0000;
    do_write(BASE, 32'h434D0100);
    repeat (15) @(posedge clk);
    #1;
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL timeout_early: valid %b want 1 after 15 cycles", cmd_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_fire: valid %b want 0 after 16 cycles", cmd_valid);
    end
    exp_q.push_back(32'h4552FFFF);
    exp_q.push_back(32'h0);
    do_read(BASE, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL timeout_status: got %h want %h", got, e);
    end
    do_read(BASE + 32'h40, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL timeout_resp: got %h want %h", got, e);
    end
    // done on the timeout cycle takes precedence
    do_write(BASE, 32'h434D0101);
    repeat (15) @(posedge clk);
    #1;
    finish_cmd(16'h0033);
    exp_q.push_back(32'h4F4B0033);
    do_read(BASE, got, got2);
    e = exp_q.pop_front();
    n_checks++;
    if (got !== e) begin
      n_fail++; $display("FAIL timeout_done_wins: got %h want %h", got, e);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_unmapped();
    test_param_stability();
    test_collision();
    test_reset_mid_valid();
`ifdef BRIDGE_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
